// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: memory waits, EX redirects and load-use bubbles.
// States: RUN = normal issue | KILL = redirect held until the in-flight wrong-path fetch returns.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IM_wait,
  input  logic             DM_wait,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [6:0]       EX_op,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic [31:0]      EX_target,
  output logic             PC_stall,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             mem_wait,
  output logic             kill_pending,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_target_q;
  logic [CNT_W-1:0] r_stall_cycles, r_redirect_count;

  logic w_load_use, w_accept, w_capture;
  logic w_pc_stall, w_pc_redirect, w_if_stall, w_if_flush;
  logic w_ix_stall, w_ix_flush, w_em_stall;

  assign w_load_use = (EX_op == 7'b0000011) && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (EX_rd == ID_rs1)) ||
                       (ID_use_rs2 && (EX_rd == ID_rs2)));

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_pc_stall    = 1'b0;
    w_pc_redirect = 1'b0;
    w_if_stall    = 1'b0;
    w_if_flush    = 1'b0;
    w_ix_stall    = 1'b0;
    w_ix_flush    = 1'b0;
    w_em_stall    = 1'b0;
    case (r_state)
      RUN: begin
        if (DM_wait) begin
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          w_ix_stall = 1'b1;
          w_em_stall = 1'b1;
        end else if (EX_redirect && !IM_wait) begin
          w_pc_redirect = 1'b1;
          w_if_flush    = 1'b1;
          w_ix_flush    = 1'b1;
          w_accept      = 1'b1;
        end else if (EX_redirect) begin
          // Fetch still busy: park the target and squash the returning word later.
          w_pc_stall = 1'b1;
          w_if_flush = 1'b1;
          w_ix_flush = 1'b1;
          w_capture  = 1'b1;
          w_accept   = 1'b1;
          w_next     = KILL;
        end else if (IM_wait || w_load_use) begin
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          w_ix_flush = 1'b1;
        end
      end
      KILL: begin
        if (DM_wait) begin
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          w_ix_stall = 1'b1;
          w_em_stall = 1'b1;
        end else if (IM_wait) begin
          w_pc_stall = 1'b1;
          w_if_flush = 1'b1;
          w_ix_flush = 1'b1;
        end else begin
          w_pc_redirect = 1'b1;
          w_if_flush    = 1'b1;
          w_ix_flush    = 1'b1;
          w_next        = RUN;
        end
      end
      default: w_next = RUN;
    endcase
  end

  assign PC_stall     = w_pc_stall    & ~rst;
  assign pc_redirect  = w_pc_redirect & ~rst;
  assign IF_ID_stall  = w_if_stall    & ~rst;
  assign IF_ID_flush  = w_if_flush    & ~rst;
  assign ID_EX_stall  = w_ix_stall    & ~rst;
  assign ID_EX_flush  = w_ix_flush    & ~rst;
  assign EX_MEM_stall = w_em_stall    & ~rst;
  assign mem_wait     = w_em_stall    & ~rst;
  assign kill_pending = (r_state == KILL) & ~rst;
  assign pc_target    = (r_state == KILL) ? r_target_q : EX_target;

  assign stall_cycles   = r_stall_cycles;
  assign redirect_count = r_redirect_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_target_q       <= 32'd0;
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture)
        r_target_q <= EX_target;
      if (w_pc_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_accept && (r_redirect_count != '1))
        r_redirect_count <= r_redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; a second 4-bit-counter instance covers saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst_sat;
  logic        IM_wait, DM_wait;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_redirect;
  logic [6:0]  EX_op;
  logic [31:0] EX_target;

  logic        PC_stall, pc_redirect, IF_ID_stall, IF_ID_flush;
  logic        ID_EX_stall, ID_EX_flush, EX_MEM_stall, mem_wait, kill_pending;
  logic [31:0] pc_target, stall_cycles, redirect_count;

  logic        s_PC_stall, s_pc_redirect, s_IF_ID_stall, s_IF_ID_flush;
  logic        s_ID_EX_stall, s_ID_EX_flush, s_EX_MEM_stall, s_mem_wait, s_kill_pending;
  logic [31:0] s_pc_target;
  logic [3:0]  s_stall_cycles, s_redirect_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [8:0] C_PCS = 9'h100, C_RED = 9'h080, C_IFS = 9'h040, C_IFF = 9'h020;
  localparam logic [8:0] C_IXS = 9'h010, C_IXF = 9'h008, C_EMS = 9'h004, C_MW  = 9'h002;
  localparam logic [8:0] C_KP  = 9'h001;
  localparam logic [8:0] C_FRZ = C_PCS | C_IFS | C_IXS | C_EMS | C_MW;

  logic [8:0] w_ctrl;
  assign w_ctrl = {PC_stall, pc_redirect, IF_ID_stall, IF_ID_flush, ID_EX_stall,
                   ID_EX_flush, EX_MEM_stall, mem_wait, kill_pending};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .IM_wait(IM_wait), .DM_wait(DM_wait),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_op(EX_op), .EX_rd(EX_rd), .EX_redirect(EX_redirect), .EX_target(EX_target),
    .PC_stall(PC_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_stall(EX_MEM_stall), .mem_wait(mem_wait), .kill_pending(kill_pending),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst_sat), .IM_wait(IM_wait), .DM_wait(DM_wait),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_op(EX_op), .EX_rd(EX_rd), .EX_redirect(EX_redirect), .EX_target(EX_target),
    .PC_stall(s_PC_stall), .pc_redirect(s_pc_redirect), .pc_target(s_pc_target),
    .IF_ID_stall(s_IF_ID_stall), .IF_ID_flush(s_IF_ID_flush),
    .ID_EX_stall(s_ID_EX_stall), .ID_EX_flush(s_ID_EX_flush),
    .EX_MEM_stall(s_EX_MEM_stall), .mem_wait(s_mem_wait), .kill_pending(s_kill_pending),
    .stall_cycles(s_stall_cycles), .redirect_count(s_redirect_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IM_wait = 0; DM_wait = 0; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_op = 0; EX_rd = 0; EX_redirect = 0; EX_target = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1; rst_sat = 1;
    IM_wait = 1;
    #1;
    chk("rst_forces_ctrl_zero", 64'(w_ctrl), 64'(9'h000));
    tick();
    tick();
    chk("rst_ctrl_zero", 64'(w_ctrl), 64'(9'h000));
    chk("rst_stall_cnt", 64'(stall_cycles), 64'd0);
    chk("rst_redir_cnt", 64'(redirect_count), 64'd0);
    rst = 0;
    clear_inputs();
    #1;
    chk("idle_ctrl", 64'(w_ctrl), 64'(9'h000));

    // load-use on rs1
    EX_op = 7'b0000011; EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
    #1;
    chk("lu_rs1_ctrl", 64'(w_ctrl), 64'(C_PCS | C_IFS | C_IXF));
    tick();
    EX_op = 7'b0110011;
    #1;
    chk("lu_after_ctrl", 64'(w_ctrl), 64'(9'h000));
    chk("lu_stall_cnt", 64'(stall_cycles), 64'd1);
    EX_op = 7'b0000011; EX_rd = 0; ID_rs1 = 0;
    #1;
    chk("lu_rd0_ctrl", 64'(w_ctrl), 64'(9'h000));
    EX_rd = 7; ID_rs1 = 3; ID_rs2 = 7; ID_use_rs1 = 1; ID_use_rs2 = 1;
    #1;
    chk("lu_rs2_ctrl", 64'(w_ctrl), 64'(C_PCS | C_IFS | C_IXF));
    ID_use_rs2 = 0;
    #1;
    chk("lu_rs2_unused_ctrl", 64'(w_ctrl), 64'(9'h000));
    ID_use_rs2 = 1;
    tick();
    clear_inputs();
    #1;
    chk("lu_rs2_stall_cnt", 64'(stall_cycles), 64'd2);

    // redirect with idle fetch
    EX_redirect = 1; EX_target = 32'h0000_0100;
    #1;
    chk("redir_ctrl", 64'(w_ctrl), 64'(C_RED | C_IFF | C_IXF));
    chk("redir_target", 64'(pc_target), 64'h100);
    tick();
    clear_inputs();
    #1;
    chk("redir_cnt", 64'(redirect_count), 64'd1);
    chk("redir_state_run", 64'(kill_pending), 64'd0);

    // redirect while fetch is waiting
    EX_redirect = 1; EX_target = 32'h0000_0200; IM_wait = 1;
    #1;
    chk("kill_entry_ctrl", 64'(w_ctrl), 64'(C_PCS | C_IFF | C_IXF));
    tick();
    EX_redirect = 0; EX_target = 32'hDEAD_BEEF;
    #1;
    chk("kill_redir_cnt", 64'(redirect_count), 64'd2);
    chk("kill_c2_ctrl", 64'(w_ctrl), 64'(C_PCS | C_IFF | C_IXF | C_KP));
    chk("kill_c2_target", 64'(pc_target), 64'h200);
    tick();
    chk("kill_c3_ctrl", 64'(w_ctrl), 64'(C_PCS | C_IFF | C_IXF | C_KP));
    tick();
    IM_wait = 0;
    #1;
    chk("kill_exit_ctrl", 64'(w_ctrl), 64'(C_RED | C_IFF | C_IXF | C_KP));
    chk("kill_exit_target", 64'(pc_target), 64'h200);
    tick();
    chk("kill_back_run", 64'(w_ctrl), 64'(9'h000));
    chk("kill_stall_cnt", 64'(stall_cycles), 64'd5);
    chk("kill_redir_cnt2", 64'(redirect_count), 64'd2);
    chk("run_target_passthru", 64'(pc_target), 64'hDEAD_BEEF);

    // data wait beats redirect and load-use
    clear_inputs();
    DM_wait = 1; EX_redirect = 1; EX_target = 32'h300;
    EX_op = 7'b0000011; EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dm_freeze_ctrl", 64'(w_ctrl), 64'(C_FRZ));
      tick();
    end
    chk("dm_stall_cnt", 64'(stall_cycles), 64'd9);
    chk("dm_redir_deferred", 64'(redirect_count), 64'd2);
    DM_wait = 0;
    #1;
    chk("dm_release_ctrl", 64'(w_ctrl), 64'(C_RED | C_IFF | C_IXF));
    chk("dm_release_target", 64'(pc_target), 64'h300);
    tick();
    clear_inputs();
    #1;
    chk("dm_redir_cnt", 64'(redirect_count), 64'd3);
    chk("dm_stall_cnt2", 64'(stall_cycles), 64'd9);

    // data wait inside KILL
    EX_redirect = 1; EX_target = 32'h380; IM_wait = 1;
    tick();
    EX_redirect = 0; EX_target = 32'h0; DM_wait = 1;
    #1;
    chk("kill_dm_ctrl", 64'(w_ctrl), 64'(C_FRZ | C_KP));
    tick();
    DM_wait = 0; IM_wait = 0;
    #1;
    chk("kill_dm_exit_ctrl", 64'(w_ctrl), 64'(C_RED | C_IFF | C_IXF | C_KP));
    chk("kill_dm_exit_target", 64'(pc_target), 64'h380);
    tick();
    chk("kill_dm_stall_cnt", 64'(stall_cycles), 64'd11);

    // reset while in KILL
    clear_inputs();
    EX_redirect = 1; EX_target = 32'h400; IM_wait = 1;
    tick();
    EX_redirect = 0;
    #1;
    chk("rk_in_kill", 64'(kill_pending), 64'd1);
    rst = 1;
    #1;
    chk("rk_rst_ctrl", 64'(w_ctrl), 64'(9'h000));
    tick();
    rst = 0; IM_wait = 0;
    #1;
    chk("rk_after_ctrl", 64'(w_ctrl), 64'(9'h000));
    chk("rk_stall_cnt", 64'(stall_cycles), 64'd0);
    chk("rk_redir_cnt", 64'(redirect_count), 64'd0);
    chk("rk_target_run", 64'(pc_target), 64'h400);

    // saturation on the 4-bit instance
    clear_inputs();
    rst_sat = 0; IM_wait = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat_cnt_14", 64'(s_stall_cycles), 64'd14);
      if (k == 15) chk("sat_cnt_15", 64'(s_stall_cycles), 64'd15);
      if (k == 20) chk("sat_cnt_20", 64'(s_stall_cycles), 64'd15);
    end
    chk("sat_redir_cnt", 64'(s_redirect_count), 64'd0);
    chk("sat_main_cnt", 64'(stall_cycles), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. It drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers; the `mem_wait` output feeds the MEM/WB register directly. It resolves three hazard sources: memory wait states, EX-stage control-flow redirects and load-use dependencies. A two-state FSM squashes a wrong-path fetch that is still in flight when a redirect occurs, and the block keeps two performance counters.

## Interface
Parameters:
- `CNT_W`, default 32, width of the performance counters.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `IM_wait`  in  1  instruction memory busy; fetch data not yet valid.
- `DM_wait`  in  1  data memory busy.
- `ID_rs1`, `ID_rs2`  in  5 each  source registers of the instruction in ID.
- `ID_use_rs1`, `ID_use_rs2`  in  1 each  the ID instruction reads rs1 / rs2.
- `EX_op`  in  7  opcode of the instruction in EX.
- `EX_rd`  in  5  destination register of the instruction in EX.
- `EX_redirect`  in  1  taken branch or jump resolved in EX.
- `EX_target`  in  32  redirect target address.
- `PC_stall`  out  1  hold the PC.
- `pc_redirect`  out  1  load the PC with `pc_target`.
- `pc_target`  out  32  redirect address.
- `IF_ID_stall`, `IF_ID_flush`  out  1 each  hold / clear the IF/ID register.
- `ID_EX_stall`, `ID_EX_flush`  out  1 each  hold / clear the ID/EX register (clear = bubble).
- `EX_MEM_stall`  out  1  hold the EX/MEM register.
- `mem_wait`  out  1  hold the MEM/WB register; always equal to `EX_MEM_stall`.
- `kill_pending`  out  1  FSM is in KILL.
- `stall_cycles`  out  CNT_W  count of cycles with `PC_stall`=1; saturating.
- `redirect_count`  out  CNT_W  count of accepted redirects; saturating.

## Operation
- `load_use` = (`EX_op`==7'b0000011) & (`EX_rd`!=0) & ((`ID_use_rs1` & `EX_rd`==`ID_rs1`) | (`ID_use_rs2` & `EX_rd`==`ID_rs2`)).
- `freeze` sets `PC_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall` and `mem_wait`.
- Registered state: FSM {RUN, KILL}, `target_q`[31:0], both counters.
- A flush always overrides a stall on the same register; the corresponding stall output is driven 0.
- All outputs not named in a case below are 0. `pc_target` = `EX_target` in RUN and `target_q` in KILL.
- RUN, in priority order:
  1. `DM_wait`: freeze. Any redirect is deferred; it stays asserted because ID/EX is held.
  2. `EX_redirect` with `IM_wait`=0: `pc_redirect`, `IF_ID_flush`, `ID_EX_flush`.
  3. `EX_redirect` with `IM_wait`=1: `PC_stall`, `IF_ID_flush`, `ID_EX_flush`, `pc_redirect`=0. Capture `target_q`←`EX_target`; next state KILL.
  4. `IM_wait`: `PC_stall`, `IF_ID_stall`, `ID_EX_flush`. EX/MEM/WB keep advancing.
  5. `load_use`: `PC_stall`, `IF_ID_stall`, `ID_EX_flush`.
- KILL:
  - `DM_wait`: freeze.
  - `IM_wait` with `DM_wait`=0: `PC_stall`, `IF_ID_flush`, `ID_EX_flush`.
  - `IM_wait`=0 and `DM_wait`=0: `pc_redirect` with `pc_target`=`target_q`, `IF_ID_flush` (drops the wrong-path word), `ID_EX_flush`; next state RUN.
  - `EX_redirect` and `load_use` are ignored. EX holds a bubble in KILL, so `EX_redirect`=1 there is a bench assertion failure.
- Counters:
  - `redirect_count` increments once per accepted redirect (RUN cases 2 and 3). A deferred redirect counts once, in the cycle it is accepted.
  - `stall_cycles` increments each cycle `PC_stall`=1.
  - Both saturate at all-ones.

## Timing
- All stall/flush/redirect outputs are combinational from the current inputs and state, with zero-cycle latency. Target pipeline registers sample them on the same `clk` edge.
- The FSM, `target_q` and the counters update on the rising edge of `clk`.
- While `rst`=1, every control output is forced to 0. At the first edge with `rst`=1: state←RUN, `target_q`←0, counters←0.
- Reset while in KILL abandons the squash. The pipeline is reset in the same cycle, so no wrong-path word survives.
- Load-use costs exactly one bubble: the cycle after, the load has moved to MEM and `load_use` is 0.
- Redirect costs two bubbles in RUN; in KILL the cost is (IM wait cycles + 1).

## Test plan
- Load-use: `EX_op`=0000011, `EX_rd`=5, `ID_rs1`=5, `ID_use_rs1`=1 -> one cycle of `PC_stall`=`IF_ID_stall`=`ID_EX_flush`=1, then all 0; `stall_cycles`=1. Repeat with `EX_rd`=0 -> no stall.
- Redirect, fetch idle: `EX_redirect`=1, `EX_target`=0x0000_0100 -> same cycle `pc_redirect`=1, `pc_target`=0x100, both flushes 1; `redirect_count`=1; state stays RUN.
- Redirect during fetch wait: `EX_redirect`=1, `EX_target`=0x200, `IM_wait`=1 held 3 cycles -> `kill_pending`=1 for 3 cycles, `pc_redirect`=0 throughout. First cycle with `IM_wait`=0 -> `pc_redirect`=1, `pc_target`=0x200, `IF_ID_flush`=1; RUN next cycle.
- Data wait priority: `DM_wait`=1 together with `EX_redirect`=1 and `load_use` for 4 cycles -> freeze only and no redirect; `stall_cycles`+=4. Redirect accepted the cycle `DM_wait` falls; `redirect_count`+=1 once.
- Reset in KILL: enter KILL, assert `rst` one cycle -> outputs 0, `kill_pending`=0 and counters 0 after the edge; a following `IM_wait`=0 produces no `pc_redirect`.
- Saturation: preload the counters near all-ones (force or `CNT_W`=4), then hold `IM_wait`=1 -> `stall_cycles` stops at 4'hF.
